// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined WIDTH-bit bitwise logic unit
//
// Purpose: eight selectable bitwise operations on a and b, with a
// valid/ready handshake on both sides, an equality flag, a parity flag and
// a completed-transaction counter. The result appears two edges after the
// beat is accepted.
//
// Optional feature: define LOGIC_UNIT_POPCNT_EN to add the popcnt output,
// which gives the number of 1s in y. It is registered together with y.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand beat handshake (a, b, op)
//   out_valid/out_ready  result beat handshake (y, eq, parity[, popcnt])
//   txn_cnt              results consumed, wraps at 2^CNT_W

module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [2:0]                   op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             y,
    output logic                         eq,
    output logic                         parity,
`ifdef LOGIC_UNIT_POPCNT_EN
    output logic [$clog2(WIDTH+1)-1:0]   popcnt,
`endif
    output logic [CNT_W-1:0]             txn_cnt
);

    // Stage 1: captured operands
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [2:0]       s1_op_q;

    // Stage 2: computed result
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             eq_q, eq_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s2_free, s1_adv, accept, consume;

    // S2 can take a new beat if it is empty or its beat leaves this edge,
    // which lets consume, S1->S2 move and a new accept share one edge.
    assign s2_free  = ~s2_valid_q | out_ready;
    assign s1_adv   = s1_valid_q & s2_free;
    assign in_ready = ~s1_valid_q | s2_free;
    assign accept   = in_valid & in_ready;
    assign consume  = s2_valid_q & out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        y_d = s1_a_q;
        unique case (s1_op_q)
            3'b000: y_d = s1_a_q & s1_b_q;
            3'b001: y_d = s1_a_q | s1_b_q;
            3'b010: y_d = s1_a_q ^ s1_b_q;
            3'b011: y_d = ~(s1_a_q ^ s1_b_q);
            3'b100: y_d = ~(s1_a_q & s1_b_q);
            3'b101: y_d = ~(s1_a_q | s1_b_q);
            3'b110: y_d = s1_a_q & ~s1_b_q;
            3'b111: y_d = s1_a_q;
            default: y_d = s1_a_q;
        endcase
        eq_d     = &(~(s1_a_q ^ s1_b_q));
        parity_d = ^y_d;
    end

    assign cnt_d = consume ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            eq_q       <= 1'b0;
            parity_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
            if (accept) begin
                s1_a_q  <= a;
                s1_b_q  <= b;
                s1_op_q <= op;
            end
            if (s1_adv) begin
                y_q      <= y_d;
                eq_q     <= eq_d;
                parity_q <= parity_d;
            end
        end
    end

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int PC_W = $clog2(WIDTH + 1);
    logic [PC_W-1:0] popcnt_q, popcnt_d;

    always_comb begin
        popcnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcnt_d = popcnt_d + PC_W'(y_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            popcnt_q <= '0;
        end else if (s1_adv) begin
            popcnt_q <= popcnt_d;
        end
    end

    assign popcnt = popcnt_q;
`endif

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign eq        = eq_q;
    assign parity    = parity_q;
    assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard bench for logic_unit_pipe

module tb_logic_unit_pipe;

    typedef struct packed {
        logic [7:0] y;
        logic       eq;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;

    logic        in_ready, out_valid, eq, parity;
    logic [7:0]  y;
    logic [15:0] txn_cnt;
    logic        in_ready_w, out_valid_w, eq_w, parity_w;
    logic [7:0]  y_w;
    logic [3:0]  txn_cnt_w;
`ifdef LOGIC_UNIT_POPCNT_EN
    logic [3:0]  popcnt, popcnt_w;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];
    int model_txn = 0;
    int stall_waits = 0;
    int cyc = 0;
    int first_cons = -1;
    int last_cons = -1;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .eq(eq), .parity(parity),
`ifdef LOGIC_UNIT_POPCNT_EN
        .popcnt(popcnt),
`endif
        .txn_cnt(txn_cnt)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
        .y(y_w), .eq(eq_w), .parity(parity_w),
`ifdef LOGIC_UNIT_POPCNT_EN
        .popcnt(popcnt_w),
`endif
        .txn_cnt(txn_cnt_w)
    );

    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
        exp_t e;
        case (mop)
            3'd0: e.y = ma & mb;
            3'd1: e.y = ma | mb;
            3'd2: e.y = ma ^ mb;
            3'd3: e.y = ~(ma ^ mb);
            3'd4: e.y = ~(ma & mb);
            3'd5: e.y = ~(ma | mb);
            3'd6: e.y = ma & ~mb;
            default: e.y = ma;
        endcase
        e.eq  = (ma == mb);
        e.par = ^e.y;
        return e;
    endfunction

    // Output monitor: samples 1 ns before each rising edge
    logic       prev_stall = 1'b0;
    logic [7:0] prev_y = '0;
    logic       prev_eq = 1'b0, prev_par = 1'b0;

    always begin
        @(negedge clk);
        #4;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                checks++;
                if (y !== prev_y || eq !== prev_eq || parity !== prev_par) begin
                    errors++;
                    $display("FAIL stall_hold y=%h eq=%b par=%b required y=%h eq=%b par=%b",
                             y, eq, parity, prev_y, prev_eq, prev_par);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y = y; prev_eq = eq; prev_par = parity;
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result y=%h required no output", y);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (y !== e.y || eq !== e.eq || parity !== e.par) begin
                        errors++;
                        $display("FAIL result y=%h eq=%b par=%b required y=%h eq=%b par=%b",
                                 y, eq, parity, e.y, e.eq, e.par);
                    end
                    checks++;
                    if (!out_valid_w || y_w !== e.y || eq_w !== e.eq || parity_w !== e.par) begin
                        errors++;
                        $display("FAIL result_w v=%b y=%h eq=%b par=%b required v=1 y=%h eq=%b par=%b",
                                 out_valid_w, y_w, eq_w, parity_w, e.y, e.eq, e.par);
                    end
`ifdef LOGIC_UNIT_POPCNT_EN
                    checks++;
                    if (popcnt !== 4'($countones(e.y)) || popcnt_w !== 4'($countones(e.y))) begin
                        errors++;
                        $display("FAIL popcnt got %0d/%0d required %0d", popcnt, popcnt_w, $countones(e.y));
                    end
`endif
                end
                checks++;
                if (txn_cnt !== 16'(model_txn)) begin
                    errors++;
                    $display("FAIL txn_cnt got %0d required %0d", txn_cnt, model_txn);
                end
                model_txn++;
                if (first_cons < 0) first_cons = cyc;
                last_cons = cyc;
            end
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top, input exp_t e);
        int w;
        @(negedge clk);
        a = ta; b = tb_; op = top; in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            if (w > 0) stall_waits++;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required 0", sbq.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        sbq.delete();
        model_txn = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || y !== 8'h00 || eq !== 1'b0 || parity !== 1'b0 || txn_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state v=%b y=%h eq=%b par=%b cnt=%0d required all 0",
                     out_valid, y, eq, parity, txn_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        out_ready = 1'b1;
        e = model(8'h12, 8'h34, 3'd1);
        send(8'h12, 8'h34, 3'd1, e);
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early out_valid=%b required 0", out_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h36) begin
            errors++;
            $display("FAIL latency_2 out_valid=%b y=%h required 1 y=36", out_valid, y);
        end
        drain();
    endtask

    task automatic test_op_sweep();
        logic [7:0] ys [8];
        logic       ps [8];
        exp_t e;
        ys = '{8'h04, 8'hFD, 8'hF9, 8'h06, 8'hFB, 8'h02, 8'hC1, 8'hC5};
        ps = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e.y = ys[i]; e.eq = 1'b0; e.par = ps[i];
            send(8'hC5, 8'h3C, 3'(i), e);
        end
        drain();
    endtask

    task automatic test_eq();
        exp_t e;
        out_ready = 1'b1;
        e.y = 8'hFF; e.eq = 1'b1; e.par = 1'b0;
        send(8'hA5, 8'hA5, 3'b011, e);
        e.y = 8'hFE; e.eq = 1'b0; e.par = 1'b1;
        send(8'hA5, 8'hA4, 3'b011, e);
        drain();
    endtask

    task automatic test_backpressure();
        exp_t e[4];
        logic [7:0] va [4];
        int start;
        va = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) e[i] = model(va[i], 8'h0F, 3'd2);
        start = model_txn;
        @(negedge clk);
        out_ready = 1'b0;
        send(va[0], 8'h0F, 3'd2, e[0]);
        send(va[1], 8'h0F, 3'd2, e[1]);
        @(negedge clk);
        a = va[2]; b = 8'h0F; op = 3'd2; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || in_ready_w !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got %b/%b required 0", in_ready, in_ready_w);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || y !== e[0].y) begin
                errors++;
                $display("FAIL bp_hold v=%b y=%h required v=1 y=%h", out_valid, y, e[0].y);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        send(va[2], 8'h0F, 3'd2, e[2]);
        send(va[3], 8'h0F, 3'd2, e[3]);
        drain();
        checks++;
        if (txn_cnt !== 16'(start + 4)) begin
            errors++;
            $display("FAIL bp_count got %0d required %0d", txn_cnt, start + 4);
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        out_ready = 1'b0;
        e = model(8'h5A, 8'hFF, 3'd0);
        send(8'h5A, 8'hFF, 3'd0, e);
        send(8'h6B, 8'hFF, 3'd0, e);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 8'h00 || txn_cnt !== 16'd0 || eq !== 1'b0 || parity !== 1'b0) begin
            errors++;
            $display("FAIL midreset v=%b y=%h cnt=%0d eq=%b par=%b required all 0",
                     out_valid, y, txn_cnt, eq, parity);
        end
        sbq.delete();
        model_txn = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat out_valid=%b required 0", out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ra, rb;
        logic [2:0] rop;
        do_reset();
        out_ready = 1'b1;
        stall_waits = 0;
        first_cons = -1;
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom_range(0, 7));
            if (i % 10 == 3) rb = ra;
            send(ra, rb, rop, model(ra, rb, rop));
        end
        drain();
        checks++;
        if (stall_waits != 0 || last_cons - first_cons != 99) begin
            errors++;
            $display("FAIL throughput stalls=%0d span=%0d required 0 and 99",
                     stall_waits, last_cons - first_cons);
        end
        checks++;
        if (txn_cnt !== 16'd100 || txn_cnt_w !== 4'd4) begin
            errors++;
            $display("FAIL tp_count got %0d/%0d required 100/4", txn_cnt, txn_cnt_w);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ra;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ra = 8'($urandom);
            send(ra, 8'h3C, 3'd6, model(ra, 8'h3C, 3'd6));
        end
        drain();
        checks++;
        if (txn_cnt_w !== 4'd1 || txn_cnt !== 16'd17) begin
            errors++;
            $display("FAIL wrap got %0d/%0d required 1/17", txn_cnt_w, txn_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_op_sweep();
        test_eq();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
